// File: rtl/sdspi_pkg.sv
// rtl/sdspi_pkg.sv - shared constants and state encoding for the SD-card SPI data stages
package sdspi_pkg;

    // CRC16-CCITT polynomial used on SD data blocks (x^16 + x^12 + x^5 + 1)
    localparam logic [15:0] CRC16_POLY  = 16'h1021;

    // Start-of-block token and the idle/fill byte clocked out while polling
    localparam logic [7:0]  TOKEN_START = 8'hFE;
    localparam logic [7:0]  TOKEN_FILL  = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TOKEN,
        S_DATA,
        S_CRC
    } rx_state_t;

endpackage

// File: rtl/sdspi_crc16_byte.sv
// rtl/sdspi_crc16_byte.sv - combinational CRC16 update over one byte, MSB first
//
// Ports:
//  i_crc   current CRC register
//  i_byte  byte to fold in, bit 7 first
//  o_crc   CRC after all 8 bits
module sdspi_crc16_byte
    import sdspi_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_crc
);

    logic [15:0] crc;
    logic        fb;

    always_comb begin
        crc = i_crc;
        fb  = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb  = crc[15] ^ i_byte[i];
            crc = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
        o_crc = crc;
    end

endmodule

// File: rtl/sdspi_rxdata.sv
// rtl/sdspi_rxdata.sv - receive data stage: token wait, word packing into block FIFOs, CRC16 check
//
// Ports:
//  i_clk, i_reset                  clock, synchronous active-high reset
//  i_start, i_lgblksz, i_fifo      start a block read of 2^i_lgblksz bytes into FIFO i_fifo
//  o_busy                          transfer in progress
//  o_write, o_addr, o_data         one-cycle FIFO write of a packed word at {fifo, index}
//  i_ll_busy, o_ll_stb, o_ll_byte  byte request to the low-level SPI engine (always 0xFF)
//  i_ll_stb, i_ll_byte             byte returned by the low-level SPI engine
//  o_done, o_err, o_response       end-of-transfer pulse and status
module sdspi_rxdata
    import sdspi_pkg::*;
#(
    parameter int       DW                = 32,
    parameter int       AW                = 8,
    parameter int       LGTIMEOUT         = 16,
    parameter bit       OPT_LITTLE_ENDIAN = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [3:0]    i_lgblksz,
    input  logic          i_fifo,
    output logic          o_busy,
    output logic          o_write,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    input  logic          i_ll_busy,
    output logic          o_ll_stb,
    output logic [7:0]    o_ll_byte,
    input  logic          i_ll_stb,
    input  logic [7:0]    i_ll_byte,
    output logic          o_done,
    output logic          o_err,
    output logic [7:0]    o_response
);

    localparam int                   BPW_LG   = $clog2(DW / 8);
    localparam logic [AW-2:0]        IDX_ONE  = {{(AW-2){1'b0}}, 1'b1};
    localparam logic [LGTIMEOUT-1:0] POLL_ONE = {{(LGTIMEOUT-1){1'b0}}, 1'b1};

    rx_state_t            state_q,  state_d;
    logic                 busy_q,   busy_d;
    logic                 write_q,  write_d;
    logic                 done_q,   done_d;
    logic                 err_q,    err_d;
    logic [7:0]           resp_q,   resp_d;
    logic [AW-1:0]        addr_q,   addr_d;
    logic [DW-1:0]        data_q,   data_d;
    logic [DW-1:0]        word_q,   word_d;
    logic                 ll_stb_q, ll_stb_d;
    logic                 pend_q,   pend_d;
    logic [15:0]          crc_q,    crc_d;
    logic [10:0]          cnt_q,    cnt_d;
    logic [LGTIMEOUT-1:0] poll_q,   poll_d;
    logic [3:0]           lgblksz_q, lgblksz_d;
    logic [7:0]           crc_hi_q, crc_hi_d;
    logic                 crc_sel_q, crc_sel_d;

    logic [15:0]          crc_next;
    logic [DW-1:0]        word_next;
    logic [10:0]          blk_bytes;
    logic                 byte_in;

    sdspi_crc16_byte u_crc (
        .i_crc  (crc_q),
        .i_byte (i_ll_byte),
        .o_crc  (crc_next)
    );

    // Only a byte answering our own outstanding request is consumed
    assign byte_in   = i_ll_stb && pend_q;
    assign blk_bytes = 11'd1 << lgblksz_q;
    assign word_next = OPT_LITTLE_ENDIAN ? {i_ll_byte, word_q[DW-1:8]}
                                         : {word_q[DW-9:0], i_ll_byte};

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        write_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        resp_d    = resp_q;
        addr_d    = addr_q;
        data_d    = data_q;
        word_d    = word_q;
        ll_stb_d  = ll_stb_q;
        pend_d    = pend_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        poll_d    = poll_q;
        lgblksz_d = lgblksz_q;
        crc_hi_d  = crc_hi_q;
        crc_sel_d = crc_sel_q;

        // Word index advances after each write; the FIFO-select bit is never touched
        if (write_q) begin
            addr_d = {addr_q[AW-1], addr_q[AW-2:0] + IDX_ONE};
        end

        // One byte in flight: request held until accepted, then wait for the reply
        if (ll_stb_q && !i_ll_busy) begin
            ll_stb_d = 1'b0;
            pend_d   = 1'b1;
        end
        if (byte_in) begin
            pend_d = 1'b0;
        end
        if (state_q != S_IDLE && !ll_stb_q && !pend_q) begin
            ll_stb_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_TOKEN;
                    busy_d    = 1'b1;
                    lgblksz_d = i_lgblksz;
                    addr_d    = {i_fifo, {(AW-1){1'b0}}};
                    crc_d     = 16'h0000;
                    cnt_d     = 11'd0;
                    poll_d    = '0;
                    crc_sel_d = 1'b0;
                    err_d     = 1'b0;
                    resp_d    = 8'h00;
                end
            end
            S_TOKEN: begin
                if (byte_in) begin
                    if (i_ll_byte == TOKEN_START) begin
                        state_d = S_DATA;
                    end else if (i_ll_byte[7:4] == 4'h0) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        resp_d  = i_ll_byte;
                    end else if (&poll_q) begin
                        // This byte was the last allowed poll
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        resp_d  = TOKEN_FILL;
                    end else begin
                        poll_d = poll_q + POLL_ONE;
                    end
                end
            end
            S_DATA: begin
                if (byte_in) begin
                    crc_d  = crc_next;
                    word_d = word_next;
                    cnt_d  = cnt_q + 11'd1;
                    if (&cnt_q[BPW_LG-1:0]) begin
                        write_d = 1'b1;
                        data_d  = word_next;
                    end
                    if (cnt_q + 11'd1 == blk_bytes) begin
                        state_d = S_CRC;
                    end
                end
            end
            S_CRC: begin
                if (byte_in) begin
                    if (!crc_sel_q) begin
                        crc_hi_d  = i_ll_byte;
                        crc_sel_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = ({crc_hi_q, i_ll_byte} != crc_q);
                        resp_d  = TOKEN_START;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            resp_q    <= 8'h00;
            addr_q    <= '0;
            data_q    <= '0;
            word_q    <= '0;
            ll_stb_q  <= 1'b0;
            pend_q    <= 1'b0;
            crc_q     <= 16'h0000;
            cnt_q     <= 11'd0;
            poll_q    <= '0;
            lgblksz_q <= 4'd0;
            crc_hi_q  <= 8'h00;
            crc_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            write_q   <= write_d;
            done_q    <= done_d;
            err_q     <= err_d;
            resp_q    <= resp_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            word_q    <= word_d;
            ll_stb_q  <= ll_stb_d;
            pend_q    <= pend_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            lgblksz_q <= lgblksz_d;
            crc_hi_q  <= crc_hi_d;
            crc_sel_q <= crc_sel_d;
        end
    end

    assign o_busy     = busy_q;
    assign o_write    = write_q;
    assign o_addr     = addr_q;
    assign o_data     = data_q;
    assign o_ll_stb   = ll_stb_q;
    assign o_ll_byte  = TOKEN_FILL;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_response = resp_q;

endmodule

// File: tb/tb_sdspi_rxdata.sv
// tb/tb_sdspi_rxdata.sv - scoreboard bench for sdspi_rxdata with a card byte-stream model
module tb_sdspi_rxdata;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic       err;
        logic [7:0] resp;
        int         polls;
    } done_t;

    logic        clk = 1'b0;
    logic        i_reset, i_start, i_fifo, i_ll_busy, i_ll_stb;
    logic [3:0]  i_lgblksz;
    logic [7:0]  i_ll_byte;
    logic        o_busy, o_write, o_ll_stb, o_done, o_err;
    logic [7:0]  o_addr, o_ll_byte, o_response;
    logic [31:0] o_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] card_q[$];
    logic [7:0] payload[$];
    wr_t        exp_wr[$];
    done_t      exp_done[$];

    int  accept_cnt = 0;
    int  done_cnt   = 0;
    int  wr_seen    = 0;
    int  hold_viol  = 0;
    int  multi_viol = 0;
    bit  busy_rand  = 0;
    int  delay      = 0;
    bit  prev_wait  = 0;
    wr_t   mon_w;
    done_t mon_d;

    always #5 clk = ~clk;

    sdspi_rxdata #(
        .DW(32), .AW(8), .LGTIMEOUT(4), .OPT_LITTLE_ENDIAN(1'b0)
    ) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_start    (i_start),
        .i_lgblksz  (i_lgblksz),
        .i_fifo     (i_fifo),
        .o_busy     (o_busy),
        .o_write    (o_write),
        .o_addr     (o_addr),
        .o_data     (o_data),
        .i_ll_busy  (i_ll_busy),
        .o_ll_stb   (o_ll_stb),
        .o_ll_byte  (o_ll_byte),
        .i_ll_stb   (i_ll_stb),
        .i_ll_byte  (i_ll_byte),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_response (o_response)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ b[i]) r = (r << 1) ^ 16'h1021;
            else              r = r << 1;
        end
        return r;
    endfunction

    // Card side: returns bytes from card_q (0xFF once empty) 1..3 cycles after acceptance
    initial begin
        i_ll_stb  = 1'b0;
        i_ll_byte = 8'h00;
        i_ll_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_wait && !o_ll_stb && !i_reset) hold_viol++;
            i_ll_stb = 1'b0;
            if (delay > 0) begin
                delay--;
                if (delay == 0) begin
                    i_ll_stb  = 1'b1;
                    i_ll_byte = (card_q.size() != 0) ? card_q.pop_front() : 8'hFF;
                end
            end
            i_ll_busy = busy_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            prev_wait = o_ll_stb && i_ll_busy && !i_reset;
            if (o_ll_stb && !i_ll_busy) begin
                if (delay != 0) multi_viol++;
                delay = $urandom_range(1, 3);
                accept_cnt++;
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (o_write) begin
                wr_seen++;
                check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
                if (exp_wr.size() != 0) begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", 64'(o_addr), 64'(mon_w.addr));
                    check("wr_data", 64'(o_data), 64'(mon_w.data));
                end
            end
            if (o_done) begin
                done_cnt++;
                check("done_expected", 64'(exp_done.size() != 0), 64'd1);
                if (exp_done.size() != 0) begin
                    mon_d = exp_done.pop_front();
                    check("done_err",  64'(o_err), 64'(mon_d.err));
                    check("done_resp", 64'(o_response), 64'(mon_d.resp));
                    check("done_busy", 64'(o_busy), 64'd0);
                    check("polls",     64'(accept_cnt), 64'(mon_d.polls));
                end
            end
        end
    end

    // Builds the card byte stream and pushes the reference outcome
    task automatic prep(input int lg, input bit fifo, input int npre, input bit noise,
                        input logic [7:0] tok, input bit corrupt);
        logic [7:0]  s[$];
        logic [15:0] crc;
        logic [7:0]  b;
        int          n, idx, polls;
        bit          fin;
        wr_t         w;
        done_t       d;
        n = 1 << lg;
        for (int i = 0; i < npre; i++)
            s.push_back((noise && $urandom_range(0, 1) == 1) ? 8'($urandom_range(16, 253)) : 8'hFF);
        s.push_back(tok);
        if (tok == 8'hFE) begin
            crc = 16'h0000;
            for (int i = 0; i < n; i++) begin
                s.push_back(payload[i]);
                crc = crc16(crc, payload[i]);
            end
            s.push_back(crc[15:8]);
            s.push_back(crc[7:0] ^ (corrupt ? 8'hFF : 8'h00));
        end
        card_q = s;
        idx = 0; polls = 0; fin = 0;
        while (!fin) begin
            b = (idx < s.size()) ? s[idx] : 8'hFF;
            idx++; polls++;
            if (b == 8'hFE) begin
                for (int k = 0; k < n / 4; k++) begin
                    w.addr = {fifo, 7'(k)};
                    w.data = {s[idx+4*k], s[idx+4*k+1], s[idx+4*k+2], s[idx+4*k+3]};
                    exp_wr.push_back(w);
                end
                crc = 16'h0000;
                for (int i = 0; i < n; i++) crc = crc16(crc, s[idx+i]);
                d.err   = ({s[idx+n], s[idx+n+1]} != crc);
                d.resp  = 8'hFE;
                d.polls = polls + n + 2;
                fin = 1;
            end else if (b[7:4] == 4'h0) begin
                d.err = 1'b1; d.resp = b; d.polls = polls; fin = 1;
            end else if (polls == 16) begin
                d.err = 1'b1; d.resp = 8'hFF; d.polls = polls; fin = 1;
            end
        end
        exp_done.push_back(d);
    endtask

    task automatic start_xfer(input int lg, input bit fifo);
        @(negedge clk);
        accept_cnt = 0;
        i_lgblksz  = 4'(lg);
        i_fifo     = fifo;
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", 64'(o_busy), 64'd1);
    endtask

    task automatic go(input int lg, input bit fifo, input bit poke);
        int d0;
        d0 = done_cnt;
        start_xfer(lg, fifo);
        if (poke) begin
            repeat (3) @(negedge clk);
            i_start = 1'b1; i_fifo = !fifo; i_lgblksz = 4'd2;
            @(negedge clk);
            i_start = 1'b0;
        end
        for (int c = 0; c < 20000 && done_cnt == d0; c++) @(negedge clk);
        check("done_seen", 64'(done_cnt != d0), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_pattern(input int n);
        payload = {};
        for (int i = 0; i < n; i++) payload.push_back(8'(i));
    endtask

    task automatic fill_random(input int n);
        payload = {};
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int w0, d0, lg;
        bit tok_ok;
        i_reset = 1'b1; i_start = 1'b0; i_fifo = 1'b0; i_lgblksz = 4'd2;
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(o_busy), 64'd0);
        check("rst_write", 64'(o_write), 64'd0);
        check("rst_llstb", 64'(o_ll_stb), 64'd0);
        check("rst_done",  64'(o_done), 64'd0);
        check("rst_err",   64'(o_err), 64'd0);
        check("rst_resp",  64'(o_response), 64'd0);
        check("rst_addr",  64'(o_addr), 64'd0);
        i_reset = 1'b0;

        // Full 512-byte block into FIFO 1, good then corrupted CRC
        fill_pattern(512);
        prep(9, 1'b1, 3, 1'b0, 8'hFE, 1'b0);
        go(9, 1'b1, 1'b0);
        prep(9, 1'b1, 3, 1'b0, 8'hFE, 1'b1);
        go(9, 1'b1, 1'b0);

        // Error token, then token timeout
        prep(2, 1'b0, 2, 1'b0, 8'h08, 1'b0);
        go(2, 1'b0, 1'b0);
        prep(4, 1'b0, 20, 1'b0, 8'hFF, 1'b0);
        go(4, 1'b0, 1'b0);

        // Single-word block with a stalling byte engine
        busy_rand = 1;
        payload = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        prep(2, 1'b0, 1, 1'b0, 8'hFE, 1'b0);
        go(2, 1'b0, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 8; t++) begin
            busy_rand = 1'($urandom_range(0, 1));
            lg = $urandom_range(2, 6);
            fill_random(1 << lg);
            tok_ok = ($urandom_range(0, 3) != 0);
            prep(lg, 1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                 tok_ok ? 8'hFE : 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            go(lg, exp_wr.size() != 0 ? exp_wr[0].addr[7] : 1'b0, tok_ok);
        end
        busy_rand = 0;

        // Reset in the middle of the data phase
        fill_random(512);
        prep(9, 1'b1, 1, 1'b0, 8'hFE, 1'b0);
        w0 = wr_seen;
        start_xfer(9, 1'b1);
        for (int c = 0; c < 5000 && wr_seen < w0 + 3; c++) @(negedge clk);
        check("mid_writes_seen", 64'(wr_seen >= w0 + 3), 64'd1);
        i_reset = 1'b1;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        exp_wr = {};
        exp_done = {};
        card_q = {};
        check("rst_mid_busy", 64'(o_busy), 64'd0);
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        check("no_done_after_rst", 64'(done_cnt), 64'(d0));
        fill_random(16);
        prep(4, 1'b0, 2, 1'b0, 8'hFE, 1'b0);
        go(4, 1'b0, 1'b0);

        check("ll_stb_held", 64'(hold_viol), 64'd0);
        check("one_outstanding", 64'(multi_viol), 64'd0);
        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("done_queue_drained", 64'(exp_done.size()), 64'd0);
        check("ll_byte_const", 64'(o_ll_byte), 64'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
